// File: rtl/fetch_queue_pkg.sv
// Shared types and default sizing for the fetch->dispatch instruction queue.
package fetch_queue_pkg;

  localparam int FQ_DEPTH    = 16;
  localparam int FQ_PUSH_W   = 4;
  localparam int FQ_POP_W    = 3;
  localparam int FQ_IDX_BITS = $clog2(FQ_DEPTH);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_packet_t;

endpackage

// File: rtl/fetch_queue_compact.sv
// Packs the valid lanes of a sparse fetch bundle into the low slots, in lane order,
// and reports how many lanes were valid.
module fetch_compact
  import fetch_queue_pkg::*;
#(
  parameter int PUSH_W = FQ_PUSH_W
) (
  input  fetch_packet_t [PUSH_W-1:0]         lanes_in,
  output fetch_packet_t [PUSH_W-1:0]         lanes_out,
  output logic [$clog2(PUSH_W+1)-1:0]        npush
);

  localparam int CNT_W = $clog2(PUSH_W+1);

  logic [CNT_W-1:0] offset [PUSH_W];

  always_comb begin : prefix_sum
    logic [CNT_W-1:0] run;
    // NOTE: blocking assignments here so the running sum is visible to the next lane in the same pass.
    run = '0;
    for (int i = 0; i < PUSH_W; i++) begin
      offset[i] = run;
      run       = run + CNT_W'(lanes_in[i].valid);
    end
    npush = run;
  end

  // Slot j takes the unique valid lane whose exclusive prefix sum equals j.
  always_comb begin
    // NOTE: default every output first; otherwise an unmatched slot would hold its value and infer a latch.
    lanes_out = '0;
    for (int j = 0; j < PUSH_W; j++) begin
      for (int i = 0; i < PUSH_W; i++) begin
        if (lanes_in[i].valid && (offset[i] == CNT_W'(j))) begin
          lanes_out[j] = lanes_in[i];
        end
      end
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Circular fetch->dispatch instruction queue: compacting multi-lane push, clamped multi-entry pop,
// flush, and explicit occupancy so any DEPTH (not only powers of two) works.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH  = FQ_DEPTH,
  parameter int PUSH_W = FQ_PUSH_W,
  parameter int POP_W  = FQ_POP_W
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  fetch_packet_t [PUSH_W-1:0]    push_pkts,
  output logic                          push_ready,
  output logic [$clog2(DEPTH+1)-1:0]    free_slots,
  input  logic [$clog2(POP_W+1)-1:0]    num_pops,
  output fetch_packet_t [POP_W-1:0]     window,
  output logic [$clog2(POP_W+1)-1:0]    window_count,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          full,
  output logic                          empty
);

  localparam int CNT_W   = $clog2(DEPTH+1);
  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int POPC_W  = $clog2(POP_W+1);
  localparam int PUSHC_W = $clog2(PUSH_W+1);

  fetch_packet_t              entries_q [DEPTH];
  fetch_packet_t              entries_d [DEPTH];
  logic [IDX_W-1:0]           head_q, head_d;
  logic [IDX_W-1:0]           tail_q, tail_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic [CNT_W-1:0]           free_q, free_d;

  fetch_packet_t [PUSH_W-1:0] packed_pkts;
  logic [PUSHC_W-1:0]         npush;
  logic [PUSHC_W-1:0]         accepted;
  logic [POPC_W-1:0]          eff_pops;

  // ptr + k never reaches 2*DEPTH, so one conditional subtract replaces a modulo.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] ptr,
                                                input logic [CNT_W-1:0] k);
    logic [CNT_W:0] sum;
    sum = (CNT_W+1)'(ptr) + (CNT_W+1)'(k);
    if (sum >= (CNT_W+1)'(DEPTH)) begin
      sum = sum - (CNT_W+1)'(DEPTH);
    end
    return sum[IDX_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] offset_from_head(input logic [IDX_W-1:0] idx);
    if (idx >= head_q) begin
      return CNT_W'(idx - head_q);
    end
    return CNT_W'(DEPTH) - CNT_W'(head_q) + CNT_W'(idx);
  endfunction

  fetch_compact #(
    .PUSH_W (PUSH_W)
  ) u_compact (
    .lanes_in  (push_pkts),
    .lanes_out (packed_pkts),
    .npush     (npush)
  );

  // Ready looks only at the registered free count, keeping dispatch off the fetch ready path.
  assign push_ready   = (CNT_W'(npush) <= free_q);
  assign accepted     = push_ready ? npush : '0;

  assign count        = count_q;
  assign free_slots   = free_q;
  assign full         = (count_q == CNT_W'(DEPTH));
  assign empty        = (count_q == '0);
  assign window_count = (count_q < CNT_W'(POP_W)) ? POPC_W'(count_q) : POPC_W'(POP_W);
  assign eff_pops     = (num_pops < window_count) ? num_pops : window_count;

  always_comb begin
    window = '0;
    for (int i = 0; i < POP_W; i++) begin
      if (CNT_W'(i) < count_q) begin
        window[i] = entries_q[wrap_add(head_q, CNT_W'(i))];
      end
    end
  end

  always_comb begin
    entries_d = entries_q;
    head_d    = wrap_add(head_q, CNT_W'(eff_pops));
    tail_d    = wrap_add(tail_q, CNT_W'(accepted));
    count_d   = count_q + CNT_W'(accepted) - CNT_W'(eff_pops);

    for (int i = 0; i < POP_W; i++) begin
      if (POPC_W'(i) < eff_pops) begin
        entries_d[wrap_add(head_q, CNT_W'(i))].valid = 1'b0;
      end
    end

    // Push targets only slots that were free last cycle, so it never collides with a same-cycle pop.
    for (int j = 0; j < PUSH_W; j++) begin
      if (PUSHC_W'(j) < accepted) begin
        entries_d[wrap_add(tail_q, CNT_W'(j))] = packed_pkts[j];
      end
    end

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      for (int k = 0; k < DEPTH; k++) begin
        entries_d[k].valid = 1'b0;
      end
    end

    free_d = CNT_W'(DEPTH) - count_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      free_q  <= CNT_W'(DEPTH);
      // NOTE: the entry array is reset so its valid bits agree with count from the first cycle; reset overrides flush/push/pop.
      for (int k = 0; k < DEPTH; k++) begin
        entries_q[k] <= '0;
      end
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      free_q    <= free_d;
      entries_q <= entries_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (count_q <= CNT_W'(DEPTH));
      assert (free_q == CNT_W'(DEPTH) - count_q);
      assert (window_count <= POPC_W'(POP_W));
      for (int k = 0; k < DEPTH; k++) begin
        assert (entries_q[k].valid == (offset_from_head(IDX_W'(k)) < count_q));
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed and random stimulus for fetch_queue with a FIFO scoreboard checked by a separate monitor.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH  = 6;
  localparam int PUSH_W = 4;
  localparam int POP_W  = 3;

  typedef fetch_packet_t [PUSH_W-1:0] bundle_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  bundle_t       push_pkts = '0;
  logic          push_ready;
  logic [2:0]    free_slots;
  logic [1:0]    num_pops = '0;
  fetch_packet_t [POP_W-1:0] window;
  logic [1:0]    window_count;
  logic [2:0]    count;
  logic          full;
  logic          empty;

  int            n_vec = 0;
  int            n_bad = 0;
  int            m_count = 0;
  int            exp_cnt = 0;
  int            exp_eff = 0;
  bit            mon_armed = 1'b0;
  fetch_packet_t sb [$];

  fetch_queue #(
    .DEPTH  (DEPTH),
    .PUSH_W (PUSH_W),
    .POP_W  (POP_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .flush        (flush),
    .push_pkts    (push_pkts),
    .push_ready   (push_ready),
    .free_slots   (free_slots),
    .num_pops     (num_pops),
    .window       (window),
    .window_count (window_count),
    .count        (count),
    .full         (full),
    .empty        (empty)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bundle_t bundle(input logic [3:0] vmask, input logic [31:0] base);
    bundle_t b;
    for (int i = 0; i < PUSH_W; i++) begin
      b[i].valid = vmask[i];
      b[i].pc    = base + 32'(i * 4);
      b[i].inst  = ~(base + 32'(i * 4));
    end
    return b;
  endfunction

  // One cycle of stimulus: inputs go on just after an edge; expectations are queued for the monitor.
  task automatic drive(input bit rst, input bit fl, input bundle_t pk, input int pops,
                       input int want_rdy = -1);
    int np;
    int wc;
    int eff;
    bit rdy;
    reset    = rst;
    flush    = fl;
    push_pkts = pk;
    num_pops = 2'(pops);
    np = 0;
    for (int i = 0; i < PUSH_W; i++) begin
      if (pk[i].valid) np++;
    end
    rdy       = (np <= DEPTH - m_count);
    wc        = (m_count < POP_W) ? m_count : POP_W;
    eff       = (pops < wc) ? pops : wc;
    exp_cnt   = m_count;
    exp_eff   = eff;
    mon_armed = !rst;
    #1;
    if (!rst) begin
      check("push_ready", push_ready, rdy);
      if (want_rdy >= 0) check("push_ready_directed", push_ready, want_rdy[0]);
      if (!fl && rdy) begin
        for (int i = 0; i < PUSH_W; i++) begin
          if (pk[i].valid) sb.push_back(pk[i]);
        end
      end
    end
    m_count = (rst || fl) ? 0 : m_count + (rdy ? np : 0) - eff;
    @(posedge clock);
    #1;
  endtask

  task automatic peek(input string tag, input int cnt);
    check({tag, "_count"},  count, cnt);
    check({tag, "_free"},   free_slots, DEPTH - cnt);
    check({tag, "_empty"},  empty, cnt == 0);
    check({tag, "_full"},   full, cnt == DEPTH);
    check({tag, "_wcount"}, window_count, (cnt < POP_W) ? cnt : POP_W);
    if (cnt == 0) begin
      for (int i = 0; i < POP_W; i++) check({tag, "_wzero"}, window[i], '0);
    end
  endtask

  // Monitor: every window lane against the scoreboard head, then retire what was popped.
  always @(negedge clock) begin
    if (reset) begin
      sb.delete();
    end else if (mon_armed) begin
      int wc;
      wc = (exp_cnt < POP_W) ? exp_cnt : POP_W;
      check("mon_count", count, exp_cnt);
      check("mon_free", free_slots, DEPTH - exp_cnt);
      check("mon_wcount", window_count, wc);
      check("mon_sb_size", sb.size() >= exp_cnt, 1'b1);
      for (int i = 0; i < POP_W; i++) begin
        if (i < wc && i < sb.size()) check($sformatf("mon_win%0d", i), window[i], sb[i]);
        else check($sformatf("mon_win%0d_zero", i), window[i], '0);
      end
      if (flush) begin
        sb.delete();
      end else begin
        for (int i = 0; i < exp_eff; i++) begin
          if (sb.size() > 0) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    bundle_t    rb;
    logic [31:0] seq;
    repeat (2) @(posedge clock);
    #1;
    drive(1, 0, '0, 0);
    peek("reset", 0);

    // Sparse push {1,0,1,1}: A,B,C become visible one cycle later.
    drive(0, 0, bundle(4'b1101, 32'h1000), 0, 1);
    peek("t1", 3);
    check("t1_w0", window[0].pc, 32'h1000);
    check("t1_w1", window[1].pc, 32'h1008);
    check("t1_w2", window[2].pc, 32'h100c);

    // 4 lanes into 3 free slots is refused even though 3 pop the same cycle.
    drive(0, 0, bundle(4'b1111, 32'h2000), 3, 0);
    peek("t2_drained", 0);
    drive(0, 0, bundle(4'b1111, 32'h2000), 0, 1);
    peek("t2_accept", 4);
    check("t2_w0", window[0].pc, 32'h2000);

    // Pop request above occupancy clamps to what is there.
    drive(0, 0, '0, 2);
    peek("t4_pre", 2);
    drive(0, 0, '0, 3);
    peek("t4", 0);

    // Move head to 4, then fill across the wrap point.
    drive(0, 0, bundle(4'b0111, 32'h3000), 0, 1);
    drive(0, 0, '0, 3);
    peek("t3_start", 0);
    check("t3_head_start", dut.head_q, 4);
    drive(0, 0, bundle(4'b1111, 32'h4000), 0, 1);
    drive(0, 0, bundle(4'b0011, 32'h5000), 0, 1);
    peek("t3_full", 6);
    drive(0, 0, bundle(4'b0001, 32'h6000), 0, 0);
    peek("t3_full_hold", 6);
    check("t3_wa0", window[0].pc, 32'h4000);
    check("t3_wa1", window[1].pc, 32'h4004);
    check("t3_wa2", window[2].pc, 32'h4008);
    drive(0, 0, '0, 3);
    check("t3_wb0", window[0].pc, 32'h400c);
    check("t3_wb1", window[1].pc, 32'h5000);
    check("t3_wb2", window[2].pc, 32'h5004);
    drive(0, 0, '0, 3);
    peek("t3_end", 0);
    check("t3_head_end", dut.head_q, 4);

    // Flush beats a same-cycle push and pop.
    drive(0, 0, bundle(4'b1111, 32'h7000), 0, 1);
    drive(0, 0, bundle(4'b0001, 32'h8000), 0, 1);
    peek("t5_pre", 5);
    drive(0, 1, bundle(4'b0001, 32'h9000), 2, 1);
    peek("t5", 0);

    // Reset in the middle of traffic.
    drive(0, 0, bundle(4'b0111, 32'ha000), 0, 1);
    drive(1, 0, bundle(4'b1111, 32'hb000), 1);
    peek("midrst", 0);

    seq = 32'h0010_0000;
    for (int c = 0; c < 10000; c++) begin
      logic [3:0] vm;
      vm = 4'($urandom);
      rb = bundle(vm, seq);
      for (int i = 0; i < PUSH_W; i++) begin
        if (!vm[i]) rb[i].inst = $urandom;
      end
      seq = seq + 32'h10;
      drive(($urandom_range(0, 999) == 0), ($urandom_range(0, 31) == 0), rb,
            $urandom_range(0, 3));
    end

    mon_armed = 1'b0;
    @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
